rand_sampler: RTL and testbench
===============================

# rand_sampler

Periodic sampler and buffer placed directly downstream of the 8-bit LFSR. It paces the generator by driving the LFSR enable once per sample interval and captures each newly produced value. Values are queued in a small show-ahead FIFO and delivered to consumers (display, game logic, UART) over a valid/ready interface. It flags dropped samples and can be started and stopped at run time without losing buffered data.

## Interface
- `WIDTH`, 8, data width; must equal the LFSR width.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `SAMPLE_DIV`, 10_000_000, WAIT-state length in cycles; ≥1. One sample every `SAMPLE_DIV`+1 cycles.
- `clk`  in  1  single system clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level/pulse; begins continuous sampling from IDLE.
- `stop`  in  1  returns to IDLE; FIFO contents are kept.
- `lfsr_en`  out  1  enable to LFSR `en`; one-cycle pulse per sample.
- `rand_in`  in  WIDTH  LFSR `rand_out`.
- `out_data`  out  WIDTH  FIFO head; valid only while `out_valid`=1.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts head this cycle.
- `count`  out  $clog2(DEPTH+1)  current FIFO occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; a sample was dropped because the FIFO was full.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states:
  - IDLE: counter held at 0.
  - WAIT: counter increments each cycle.
  - SAMPLE: one cycle.
- FSM transitions:
  - IDLE → WAIT when `start`=1 and `stop`=0; counter ← 0.
  - WAIT: when counter = `SAMPLE_DIV`-1, `lfsr_en`=1 for this cycle; next state SAMPLE, counter ← 0.
  - SAMPLE: `rand_in` now holds the freshly advanced LFSR value and is pushed; next state WAIT.
  - `stop`=1 in WAIT or SAMPLE → IDLE next cycle. `stop` takes priority over everything, including a same-cycle `start`. If `stop` arrives in SAMPLE, that cycle's push still occurs.
  - `start` in WAIT or SAMPLE is ignored.
- `lfsr_en` is combinational from state and counter: (state=WAIT) ∧ (counter=`SAMPLE_DIV`-1). It is never high in IDLE or SAMPLE.
- FIFO:
  - Circular buffer with `$clog2(DEPTH)`-bit read/write pointers that wrap modulo DEPTH, plus a separate occupancy counter.
  - pop = `out_valid` ∧ `out_ready`.
  - push = SAMPLE ∧ (`count`<DEPTH ∨ pop).
  - Push and pop in the same cycle: `count` unchanged, both pointers advance. This also applies when full: the pop frees a slot and the push is accepted.
  - SAMPLE with FIFO full and no pop: sample dropped, `overflow` ← 1. `overflow` is cleared only by `rst`.
  - `out_data` = mem[rd_ptr] (show-ahead). `out_valid` = (`count`≠0).
  - `out_ready` while empty has no effect.
- Sampling does not depend on consumer activity; the consumer may drain while the block is in IDLE.

## Timing
- Reset (async assert, released synchronously by system): state IDLE, counter 0, pointers 0, `count`=0, `out_valid`=0, `out_data`=0 (memory cleared), `overflow`=0, `busy`=0, `lfsr_en`=0.
- `rst` asserted mid-operation: immediate return to the reset values above; buffered data is discarded.
- `start` sampled at edge N: `busy`=1 from cycle N+1.
- First `lfsr_en` pulse is in cycle N+`SAMPLE_DIV`. Push at the end of cycle N+`SAMPLE_DIV`+1. `out_valid`=1 from cycle N+`SAMPLE_DIV`+2.
- Later `lfsr_en` pulses are spaced exactly `SAMPLE_DIV`+1 cycles apart.
- Pop latency: the next head appears on `out_data` the cycle after the pop.
- Throughput: one push and one pop per cycle maximum.

## Test plan
All scenarios use `SAMPLE_DIV`=3, `DEPTH`=4, paired with the team's 8-bit LFSR (seed 0x01, taps x^8+x^6+x^5+x^4+1, sharing `clk`; the LFSR's own reset is released first).

- **Basic pacing:** `start` pulse at edge 0, `out_ready`=1 → `lfsr_en` high in cycles 3, 7, 11; `out_data` sequence 0x02, 0x04, 0x08, 0x11, each presented with `out_valid`=1.
- **Fill and overflow:** `out_ready`=0, run 5 samples → `count`=4 after the 4th push; `overflow`=1 after the 5th. Then drain with `out_ready`=1 → 0x02, 0x04, 0x08, 0x11, and 0x23 is absent. `overflow` stays 1.
- **Full with simultaneous pop:** FIFO full, `out_ready` pulsed exactly in a SAMPLE cycle → `count` stays 4, `overflow` stays 0, head advances by one entry.
- **Stop/restart:** `stop` during WAIT → `busy`=0 next cycle, no further `lfsr_en`, FIFO contents remain poppable. `start`+`stop` in the same cycle from IDLE → stays IDLE. Restart → LFSR continues from its last value.
- **Wrap-around:** 10 samples with a consumer popping every 4th cycle → pointers wrap at least twice; output order equals LFSR order; no drops.
- **Async reset mid-run:** `rst` asserted between clock edges while in SAMPLE with `count`=2 → all outputs reach their reset values before the next edge; `lfsr_en`=0.

Source files
------------

// File: rtl/rand_sampler.sv
// ============================================================================
// Module   : rand_sampler
// Brief    : Paces an 8-bit LFSR, captures each new value into a show-ahead
//            FIFO and delivers it over valid/ready with sticky overflow flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rand_sampler #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int SAMPLE_DIV = 10_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    output logic                       lfsr_en,
    input  logic [WIDTH-1:0]           rand_in,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       busy
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SAMPLE_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_DIV_W-1:0] r_div;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;

    logic w_pop;
    logic w_full;
    logic w_sample;
    logic w_push;

    assign w_pop    = (r_count != '0) && out_ready;
    assign w_full   = (r_count == c_FULL);
    assign w_sample = (r_state == ST_SAMPLE);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push   = w_sample && (!w_full || w_pop);

    assign lfsr_en   = (r_state == ST_WAIT) && (r_div == c_DIV_LAST);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign overflow  = r_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_div <= '0;
                    if (start && !stop) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_div   <= '0;
                    end else if (r_div == c_DIV_LAST) begin
                        r_state <= ST_SAMPLE;
                        r_div   <= '0;
                    end else begin
                        r_div <= r_div + c_DIV_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    r_div   <= '0;
                    r_state <= stop ? ST_IDLE : ST_WAIT;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_div   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= rand_in;
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_sample && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rand_sampler.sv
// ============================================================================
// Module   : tb_rand_sampler
// Brief    : Self-checking bench for rand_sampler paired with an 8-bit LFSR.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rand_sampler;

    localparam int SD    = 3;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lrst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       out_ready = 1'b0;
    logic       lfsr_en;
    logic [7:0] rand_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic [2:0] count;
    logic       overflow;
    logic       busy;

    rand_sampler #(.WIDTH(8), .DEPTH(DEPTH), .SAMPLE_DIV(SD)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .lfsr_en(lfsr_en),
        .rand_in(rand_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .count(count), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // Companion LFSR: seed 0x01, x^8+x^6+x^5+x^4+1
    always_ff @(posedge clk or posedge lrst) begin
        if (lrst)         rand_in <= 8'h01;
        else if (lfsr_en) rand_in <= {rand_in[6:0], rand_in[7] ^ rand_in[5] ^ rand_in[4] ^ rand_in[3]};
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model: elapsed cycles since start plus a queue of buffered values
    bit         m_busy;
    int         m_k;
    logic [7:0] m_q[$];
    bit         m_ovf;
    logic [7:0] m_lfsr;
    int         m_nsamp;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic bit m_en();
        return m_busy && ((m_k % (SD + 1)) == SD - 1);
    endfunction

    function automatic bit m_smp();
        return m_busy && ((m_k % (SD + 1)) == SD);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("lfsr_en", {31'd0, lfsr_en}, {31'd0, m_en()});
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
        chk("count", {29'd0, count}, m_q.size());
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (m_q.size() != 0) chk("out_data", {24'd0, out_data}, {24'd0, m_q[0]});
    endtask

    // Called at a negedge: check, drive, advance model, move to next negedge.
    task automatic cycle(input logic st, input logic sp, input logic rdy);
        bit en, smp, pop, full;
        model_check();
        start = st; stop = sp; out_ready = rdy;
        en   = m_en();
        smp  = m_smp();
        pop  = (m_q.size() != 0) && rdy;
        full = (m_q.size() == DEPTH);
        if (pop) void'(m_q.pop_front());
        if (smp) begin
            m_nsamp++;
            if (!full || pop) m_q.push_back(m_lfsr);
            else              m_ovf = 1'b1;
        end
        if (en) m_lfsr = lfsr_next(m_lfsr);
        if (!m_busy) begin
            if (st && !sp) begin m_busy = 1'b1; m_k = 0; end
        end else if (sp) m_busy = 1'b0;
        else             m_k++;
        @(negedge clk);
    endtask

    task automatic model_reset(input bit lf);
        m_busy = 1'b0; m_k = 0; m_q.delete(); m_ovf = 1'b0; m_nsamp = 0;
        if (lf) m_lfsr = 8'h01;
    endtask

    task automatic do_reset(input bit lf);
        rst = 1'b1; lrst = lf; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        lrst = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset(lf);
    endtask

    typedef struct {
        logic       st, sp, rdy;
        logic       en, bsy, vld;
        logic [7:0] data;
        int         cnt;
    } vec_t;

    vec_t       tbl[18];
    logic [7:0] drain_exp[4];
    int         guard;

    initial begin
        // Basic pacing from cycle 0 (start sampled at edge 0), consumer always ready
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04, 1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h08, 1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1};
        drain_exp[0] = 8'h02; drain_exp[1] = 8'h04; drain_exp[2] = 8'h08; drain_exp[3] = 8'h11;

        do_reset(1'b1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_lfsr_en", {31'd0, lfsr_en}, 0);
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_count", {29'd0, count}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_data", {24'd0, out_data}, 0);

        for (int i = 0; i < 18; i++) begin
            chk("tbl_lfsr_en", {31'd0, lfsr_en}, {31'd0, tbl[i].en});
            chk("tbl_busy", {31'd0, busy}, {31'd0, tbl[i].bsy});
            chk("tbl_valid", {31'd0, out_valid}, {31'd0, tbl[i].vld});
            chk("tbl_count", {29'd0, count}, tbl[i].cnt);
            if (tbl[i].vld) chk("tbl_data", {24'd0, out_data}, {24'd0, tbl[i].data});
            cycle(tbl[i].st, tbl[i].sp, tbl[i].rdy);
        end

        // Fill and overflow with a stalled consumer
        do_reset(1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        guard = 0;
        while (m_nsamp < 4 && guard < 100) begin cycle(1'b0, 1'b0, 1'b0); guard++; end
        chk("fill4_bound", guard < 100, 1);
        chk("fill4_count", {29'd0, count}, 4);
        chk("fill4_overflow", {31'd0, overflow}, 0);
        guard = 0;
        while (m_nsamp < 5 && guard < 100) begin cycle(1'b0, 1'b0, 1'b0); guard++; end
        chk("fill5_bound", guard < 100, 1);
        chk("fill5_count", {29'd0, count}, 4);
        chk("fill5_overflow", {31'd0, overflow}, 1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("stop_busy", {31'd0, busy}, 0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", {24'd0, out_data}, {24'd0, drain_exp[i]});
            cycle(1'b0, 1'b0, 1'b1);
        end
        chk("drain_empty", {31'd0, out_valid}, 0);
        chk("drain_overflow", {31'd0, overflow}, 1);

        // Full FIFO with a pop in exactly the SAMPLE cycle
        do_reset(1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        guard = 0;
        while (m_nsamp < 4 && guard < 100) begin cycle(1'b0, 1'b0, 1'b0); guard++; end
        chk("full_count", {29'd0, count}, 4);
        chk("full_head", {24'd0, out_data}, 32'h47);
        guard = 0;
        while (!m_smp() && guard < 100) begin cycle(1'b0, 1'b0, 1'b0); guard++; end
        chk("full_smp_bound", guard < 100, 1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("fullpop_count", {29'd0, count}, 4);
        chk("fullpop_overflow", {31'd0, overflow}, 0);
        chk("fullpop_head", {24'd0, out_data}, 32'h8E);

        // Stop, start+stop from IDLE, drain while idle, then restart
        cycle(1'b0, 1'b1, 1'b0);
        chk("stop2_busy", {31'd0, busy}, 0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("startstop_busy", {31'd0, busy}, 0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0);
        chk("idle_kept", {29'd0, count}, 4);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1);

        // Wrap-around: consumer pops every 4th cycle
        m_nsamp = 0;
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 48; i++) cycle(1'b0, 1'b0, (i % 4) == 3);
        chk("wrap_samples", m_nsamp >= 10, 1);
        chk("wrap_overflow", {31'd0, overflow}, 0);

        // Asynchronous reset in a SAMPLE cycle with two entries buffered
        do_reset(1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        guard = 0;
        while (!(m_smp() && m_q.size() == 2) && guard < 100) begin cycle(1'b0, 1'b0, 1'b0); guard++; end
        chk("arst_bound", guard < 100, 1);
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_lfsr_en", {31'd0, lfsr_en}, 0);
        chk("arst_valid", {31'd0, out_valid}, 0);
        chk("arst_count", {29'd0, count}, 0);
        chk("arst_overflow", {31'd0, overflow}, 0);
        chk("arst_data", {24'd0, out_data}, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset(1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 1) == 1);
        end
        model_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
